logic_delay_sequencer: RTL and testbench

- Cycle-based output sequencer for one mapped logic-gate instance.
- Accepts the gate's evaluated logic value, schedules each output transition after DELAY cycles plus RISE or FALL cycles, and holds pending transitions in a small timestamped event queue.
- Sits between the shared gate evaluator and the gate's output node, so the delay, rise and fall figures of the logic model become discrete clocked events.

---
 rtl/logic_delay_sequencer.sv | 135 +++++++++++++
 tb/tb_logic_delay_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/logic_delay_sequencer.sv
// Clocked output sequencer for one gate instance: schedules delayed output transitions in a timestamped event queue.
// Define LOGIC_DELAY_INERTIAL_EN for inertial delay (a new change cancels the newest pending event); default is transport.
module logic_delay_sequencer #(
  parameter int DELAY = 1,
  parameter int RISE  = 1,
  parameter int FALL  = 1,
  parameter int DEPTH = 4,
  parameter int TW    = 8,
  parameter bit INIT  = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     d,
  input  logic                     clr_ovf,
  output logic                     q,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     full,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LAT_R_I = (DELAY + RISE < 1) ? 1 : DELAY + RISE;
  localparam int LAT_F_I = (DELAY + FALL < 1) ? 1 : DELAY + FALL;
  localparam logic [TW-1:0] LAT_R = TW'(LAT_R_I);
  localparam logic [TW-1:0] LAT_F = TW'(LAT_F_I);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [TW-1:0] now_q, now_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_q, out_d;
  logic          ovf_q, ovf_d;

  logic          ev_val_q [DEPTH];
  logic [TW-1:0] ev_due_q [DEPTH];

  logic [PW-1:0] tail_idx;
  logic          head_val, tail_val;
  logic [TW-1:0] head_due, tail_due;
  logic          empty, tv, pop, change;
  logic [TW-1:0] calc_due, gap, push_due;
  logic          push, unpush, drop;

  always_comb begin
    tail_idx = tail_q - PW'(1);
    head_val = ev_val_q[head_q];
    head_due = ev_due_q[head_q];
    tail_val = ev_val_q[tail_idx];
    tail_due = ev_due_q[tail_idx];
    empty    = (count_q == '0);
    tv       = empty ? out_q : tail_val;
    pop      = !empty && (head_due == now_q);
    change   = en && (d != tv);
    calc_due = now_q + (d ? LAT_R : LAT_F);
    // Modular distance to the tail; zero or negative means the new event would not be strictly later.
    gap      = calc_due - tail_due;
    push_due = (!empty && ((gap == '0) || gap[TW-1])) ? tail_due + TW'(1) : calc_due;
  end

`ifdef LOGIC_DELAY_INERTIAL_EN
  always_comb begin
    push   = 1'b0;
    unpush = 1'b0;
    drop   = 1'b0;
    if (change) begin
      // A lone head popping this cycle leaves the queue empty, so the change is queued fresh.
      if (empty || ((count_q == CW'(1)) && pop)) begin
        push = 1'b1;
      end else begin
        unpush = 1'b1;
      end
    end
  end
`else
  always_comb begin
    push   = change && ((count_q != DEPTH_C) || pop);
    unpush = 1'b0;
    drop   = change && !push;
  end
`endif

  always_comb begin
    now_d   = now_q + TW'(1);
    head_d  = pop ? head_q + PW'(1) : head_q;
    tail_d  = tail_q;
    if (push) begin
      tail_d = tail_q + PW'(1);
    end else if (unpush) begin
      tail_d = tail_idx;
    end
    count_d = count_q + CW'(push) - CW'(pop) - CW'(unpush);
    out_d   = pop ? head_val : out_q;
    ovf_d   = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      now_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      out_q   <= INIT;
      ovf_q   <= 1'b0;
    end else begin
      now_q   <= now_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  // Slot contents need no reset: only entries inside the head/count window are ever read.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      ev_val_q[tail_q] <= d;
      ev_due_q[tail_q] <= push_due;
    end
  end

  assign q        = out_q;
  assign pending  = count_q;
  assign full     = (count_q == DEPTH_C);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_logic_delay_sequencer.sv
// Directed bench for logic_delay_sequencer: per-edge vector table across four parameterisations plus latency sequences.
module tb_logic_delay_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en, d, clr_ovf;
  logic [3:0] q_v, full_v, ovf_v;
  logic [2:0] p0, p1, p3;
  logic [1:0] p2;

  // DUT0: rise/fall ordering and reset; DUT1: overflow; DUT2: timestamp wrap; DUT3: inertial/transport pulse
  logic_delay_sequencer #(.DELAY(2), .RISE(3), .FALL(1), .DEPTH(4), .TW(8), .INIT(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .en(en), .d(d), .clr_ovf(clr_ovf),
    .q(q_v[0]), .pending(p0), .full(full_v[0]), .overflow(ovf_v[0]));
  logic_delay_sequencer #(.DELAY(20), .RISE(1), .FALL(1), .DEPTH(4), .TW(8), .INIT(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .d(d), .clr_ovf(clr_ovf),
    .q(q_v[1]), .pending(p1), .full(full_v[1]), .overflow(ovf_v[1]));
  logic_delay_sequencer #(.DELAY(5), .RISE(0), .FALL(0), .DEPTH(2), .TW(4), .INIT(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .d(d), .clr_ovf(clr_ovf),
    .q(q_v[2]), .pending(p2), .full(full_v[2]), .overflow(ovf_v[2]));
  logic_delay_sequencer #(.DELAY(4), .RISE(0), .FALL(0), .DEPTH(4), .TW(8), .INIT(1'b0)) u_dut3 (
    .clk(clk), .reset(reset), .en(en), .d(d), .clr_ovf(clr_ovf),
    .q(q_v[3]), .pending(p3), .full(full_v[3]), .overflow(ovf_v[3]));

  typedef struct {
    string      name;
    int         sel;
    logic       rst, en, d, clr;
    logic       eq;
    logic [2:0] ep;
    logic       ef, eo;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input int n, input string nm, input int sel,
                     input logic rst_i, input logic en_i, input logic d_i, input logic clr_i,
                     input logic eq, input logic [2:0] ep, input logic ef, input logic eo);
    vec_t v;
    v.name = nm; v.sel = sel; v.rst = rst_i; v.en = en_i; v.d = d_i; v.clr = clr_i;
    v.eq = eq; v.ep = ep; v.ef = ef; v.eo = eo;
    repeat (n) vq.push_back(v);
  endtask

  function automatic logic [2:0] pend_of(input int s);
    case (s)
      0: return p0;
      1: return p1;
      2: return {1'b0, p2};
      default: return p3;
    endcase
  endfunction

  task automatic chk(input string nm, input int idx, input string field,
                     input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec%0d %s: got %0d want %0d", nm, idx, field, act, exp);
  endtask

  task automatic drive(input logic rst_i, input logic en_i, input logic d_i, input logic clr_i);
    reset = rst_i; en = en_i; d = d_i; clr_ovf = clr_i;
    @(posedge clk);
    #1;
  endtask

  // Measures edges from a change to its appearance on q of one DUT (queue assumed empty).
  task automatic lat_test(input string nm, input int sel, input logic do_rst, input int idle,
                          input logic dv, input int exp);
    int cyc;
    bit found;
    if (do_rst) drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (idle) drive(1'b0, 1'b0, dv, 1'b0);
    drive(1'b0, 1'b1, dv, 1'b0);
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 40) begin
      drive(1'b0, 1'b0, dv, 1'b0);
      cyc++;
      if (q_v[sel] === dv) found = 1'b1;
    end
    n_checks++;
    if (found && cyc == exp) n_pass++;
    else $display("FAIL %s latency: got %0d (seen=%0b) want %0d", nm, cyc, found, exp);
    $display("lat %s: %0d edges", nm, cyc);
  endtask

  initial begin
    // basic rise on DUT0: LAT=5
    add(1, "rise", 0, 1,0,0,0, 0,3'd0,0,0);
    add(4, "rise", 0, 0,0,0,0, 0,3'd0,0,0);
    add(1, "rise", 0, 0,1,1,0, 0,3'd1,0,0);
    add(4, "rise", 0, 0,1,1,0, 0,3'd1,0,0);
    add(2, "rise", 0, 0,0,1,0, 1,3'd0,0,0);

`ifndef LOGIC_DELAY_INERTIAL_EN
    // fall ordering on DUT0: fall due bumped behind the rise
    add(1, "fall", 0, 1,0,0,0, 0,3'd0,0,0);
    add(4, "fall", 0, 0,0,0,0, 0,3'd0,0,0);
    add(1, "fall", 0, 0,1,1,0, 0,3'd1,0,0);
    add(1, "fall", 0, 0,1,0,0, 0,3'd2,0,0);
    add(3, "fall", 0, 0,0,0,0, 0,3'd2,0,0);
    add(1, "fall", 0, 0,0,0,0, 1,3'd1,0,0);
    add(2, "fall", 0, 0,0,0,0, 0,3'd0,0,0);

    // overflow on DUT1: 4 accepted, 2 drops, set-wins, clear, push-on-full-with-pop, drain
    add(1, "ovf", 1, 1,0,0,0, 0,3'd0,0,0);
    add(1, "ovf", 1, 0,1,1,0, 0,3'd1,0,0);
    add(1, "ovf", 1, 0,1,0,0, 0,3'd2,0,0);
    add(1, "ovf", 1, 0,1,1,0, 0,3'd3,0,0);
    add(1, "ovf", 1, 0,1,0,0, 0,3'd4,1,0);
    add(2, "ovf", 1, 0,1,1,0, 0,3'd4,1,1);
    add(1, "ovf", 1, 0,1,1,1, 0,3'd4,1,1);
    add(1, "ovf", 1, 0,0,1,1, 0,3'd4,1,0);
    add(13, "ovf", 1, 0,0,1,0, 0,3'd4,1,0);
    add(1, "ovf", 1, 0,1,1,0, 1,3'd4,1,0);
    add(1, "ovf", 1, 0,0,1,0, 0,3'd3,0,0);
    add(1, "ovf", 1, 0,0,1,0, 1,3'd2,0,0);
    add(1, "ovf", 1, 0,0,1,0, 0,3'd1,0,0);
    add(17, "ovf", 1, 0,0,1,0, 0,3'd1,0,0);
    add(2, "ovf", 1, 0,0,1,0, 1,3'd0,0,0);

    // reset mid-operation on DUT0 with full queue and overflow set
    add(1, "rstmid", 0, 1,0,0,0, 0,3'd0,0,0);
    add(1, "rstmid", 0, 0,1,1,0, 0,3'd1,0,0);
    add(1, "rstmid", 0, 0,1,0,0, 0,3'd2,0,0);
    add(1, "rstmid", 0, 0,1,1,0, 0,3'd3,0,0);
    add(1, "rstmid", 0, 0,1,0,0, 0,3'd4,1,0);
    add(1, "rstmid", 0, 0,1,1,0, 0,3'd4,1,1);
    add(1, "rstmid", 0, 1,1,1,0, 0,3'd0,0,0);
    add(8, "rstmid", 0, 0,0,0,0, 0,3'd0,0,0);

    // transport pulse on DUT3: both edges of a short pulse are delivered
    add(1, "pulse", 3, 1,0,0,0, 0,3'd0,0,0);
    add(2, "pulse", 3, 0,0,0,0, 0,3'd0,0,0);
    add(1, "pulse", 3, 0,1,1,0, 0,3'd1,0,0);
    add(1, "pulse", 3, 0,0,1,0, 0,3'd1,0,0);
    add(1, "pulse", 3, 0,1,0,0, 0,3'd2,0,0);
    add(1, "pulse", 3, 0,0,0,0, 0,3'd2,0,0);
    add(2, "pulse", 3, 0,0,0,0, 1,3'd1,0,0);
    add(2, "pulse", 3, 0,0,0,0, 0,3'd0,0,0);
`else
    // inertial fall on DUT0: the fall cancels the pending rise
    add(1, "fall", 0, 1,0,0,0, 0,3'd0,0,0);
    add(4, "fall", 0, 0,0,0,0, 0,3'd0,0,0);
    add(1, "fall", 0, 0,1,1,0, 0,3'd1,0,0);
    add(1, "fall", 0, 0,1,0,0, 0,3'd0,0,0);
    add(6, "fall", 0, 0,0,0,0, 0,3'd0,0,0);

    // inertial pulse on DUT3: swallowed, q never moves
    add(1, "pulse", 3, 1,0,0,0, 0,3'd0,0,0);
    add(2, "pulse", 3, 0,0,0,0, 0,3'd0,0,0);
    add(1, "pulse", 3, 0,1,1,0, 0,3'd1,0,0);
    add(1, "pulse", 3, 0,0,1,0, 0,3'd1,0,0);
    add(1, "pulse", 3, 0,1,0,0, 0,3'd0,0,0);
    add(5, "pulse", 3, 0,0,0,0, 0,3'd0,0,0);
`endif

    // timestamp wrap on DUT2 (TW=4): change at now=13, due wraps to 2
    add(1, "wrap", 2, 1,0,0,0, 0,3'd0,0,0);
    add(13, "wrap", 2, 0,0,0,0, 0,3'd0,0,0);
    add(1, "wrap", 2, 0,1,1,0, 0,3'd1,0,0);
    add(4, "wrap", 2, 0,0,1,0, 0,3'd1,0,0);
    add(2, "wrap", 2, 0,0,1,0, 1,3'd0,0,0);

    for (int i = 0; i < vq.size(); i++) begin
      int s;
      s = vq[i].sel;
      drive(vq[i].rst, vq[i].en, vq[i].d, vq[i].clr);
      chk(vq[i].name, i, "q",        {2'b00, q_v[s]},    {2'b00, vq[i].eq});
      chk(vq[i].name, i, "pending",  pend_of(s),         vq[i].ep);
      chk(vq[i].name, i, "full",     {2'b00, full_v[s]}, {2'b00, vq[i].ef});
      chk(vq[i].name, i, "overflow", {2'b00, ovf_v[s]},  {2'b00, vq[i].eo});
      $display("vec %0d %s dut%0d rst=%0b en=%0b d=%0b clr=%0b -> q=%0b pend=%0d full=%0b ovf=%0b",
               i, vq[i].name, s, vq[i].rst, vq[i].en, vq[i].d, vq[i].clr,
               q_v[s], pend_of(s), full_v[s], ovf_v[s]);
    end

    lat_test("dut0_rise", 0, 1'b1, 2,  1'b1, 5);
    lat_test("dut0_fall", 0, 1'b0, 1,  1'b0, 3);
    lat_test("dut2_wrap", 2, 1'b1, 13, 1'b1, 5);
    lat_test("dut3_rise", 3, 1'b1, 3,  1'b1, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
